mux_8_1: RTL and testbench
==========================

// Module: mux_8_1
// PURPOSE
//   Registered 8-to-1 data multiplexer: one of eight WIDTH-bit inputs a_1..a_8 is chosen by a 3-bit select.
//   The choice is captured into an output register.
//   Generic datapath steering block used wherever one of eight lanes feeds a single downstream consumer.
//   One clock domain; asynchronous active-low reset.
// PARAMETERS
//   WIDTH    8    bit width of each data input and of y
// PORTS
//   clk        in   1      sole clock; all state updates on rising edge
//   rst_n      in   1      reset, asynchronous assert, active-low
//   a_1..a_8   in   WIDTH  data inputs; a_1 selected by sel=0 ... a_8 by sel=7
//   sel        in   3      select code, unsigned 0..7
//   in_valid   in   1      qualifies a_*/sel this cycle
//   y          out  WIDTH  registered selected data
//   out_valid  out  1      y holds a freshly captured selection
//   y_par      out  1      even parity of y (only with MUX_8_1_PARITY_EN)
// BEHAVIOUR
//   - One clock domain: clk. Reset is asynchronous and active-low (rst_n).
//   - Reset, while rst_n=0: y=0, out_valid=0, y_par=0. Immediate, no clock needed. Registers leave reset on the first rising clk with rst_n=1.
//   - Mapping: sel=k (k=0..7) selects a_(k+1). Every 3-bit code is legal; there are no default or X cases.
//   - Capture: on each rising clk with in_valid=1, y <= a_(sel+1) and out_valid <= 1.
//   - Hold: on a rising clk with in_valid=0, y keeps its value and out_valid <= 0.
//   - Latency is exactly 1 cycle, from sampled inputs to y. There is no backpressure and no ready signal; back-to-back captures every cycle are supported.
//   - Changes on a_* or sel between edges have no effect on y. The combinational path stops at the register.
//   - Reset mid-stream: any capture in flight is discarded. After release, y=0 until the next in_valid cycle.
//   - No arithmetic: y is a bit-exact copy of the chosen input. WIDTH applies uniformly; no truncation or extension.
// CONFIGURATION
//   MUX_8_1_PARITY_EN defined:
//     - y_par port present.
//     - y_par is registered alongside y, with y_par == ^y in the same cycle.
//     - y_par updates only on capture; reset value 0.
//   MUX_8_1_PARITY_EN undefined:
//     - y_par port absent.
//     - No parity logic; all other behaviour unchanged.
// STRUCTURE
//   - Shared package mux_8_1_pkg:
//     - localparams NUM_IN=8 and SEL_W=3.
//     - typedef sel_t = logic [SEL_W-1:0].
//   - Sub-module mux_8_1_sel: purely combinational 8:1 selector (WIDTH param, a_1..a_8, sel -> d).
//   - Top level adds the capture register, the valid flop and the optional parity flop.
// TESTING
//   1. Reset: rst_n=0 mid-cycle with prior y=8'hA5 -> y=0 and out_valid=0 immediately, with no clk edge needed.
//   2. Sweep: a_k = 8'h10+k; for sel=0..7 with in_valid=1 -> one cycle later y = 8'h11..8'h18 respectively, and out_valid=1.
//   3. Top code: sel=3'b111, a_8=8'hFF, other inputs 0 -> y=8'hFF.
//      This also covers a signed -1 truncated to 3 bits selecting a_8.
//   4. Hold: capture 8'h3C, then in_valid=0 while a_* and sel toggle for 5 cycles -> y stays 8'h3C and out_valid=0.
//   5. Random: 10 cycles of random a_* (0..8'hFF) and random sel -> y matches a reference model each following cycle.
//   6. Parity (MUX_8_1_PARITY_EN): capture 8'h07 -> y_par=1; capture 8'h03 -> y_par=0.

Source files
------------

// File: rtl/mux_8_1_pkg.sv
// Shared constants and types for the registered 8-to-1 multiplexer.
// The optional parity output is enabled by defining MUX_8_1_PARITY_EN.
package mux_8_1_pkg;

  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_8_1_sel.sv
// Purely combinational 8:1 lane selector; every 3-bit select code maps to one input.
module mux_8_1_sel
  import mux_8_1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] a_2,
  input  logic [WIDTH-1:0] a_3,
  input  logic [WIDTH-1:0] a_4,
  input  logic [WIDTH-1:0] a_5,
  input  logic [WIDTH-1:0] a_6,
  input  logic [WIDTH-1:0] a_7,
  input  logic [WIDTH-1:0] a_8,
  input  sel_t             sel,
  output logic [WIDTH-1:0] d
);

  always_comb begin
    d = a_1;
    case (sel)
      3'd0: d = a_1;
      3'd1: d = a_2;
      3'd2: d = a_3;
      3'd3: d = a_4;
      3'd4: d = a_5;
      3'd5: d = a_6;
      3'd6: d = a_7;
      3'd7: d = a_8;
    endcase
  end

endmodule

// File: rtl/mux_8_1.sv
// Registered 8-to-1 multiplexer with a one-cycle capture path and a valid flag.
// Define MUX_8_1_PARITY_EN to add a registered even-parity output y_par.
module mux_8_1
  import mux_8_1_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] a_2,
  input  logic [WIDTH-1:0] a_3,
  input  logic [WIDTH-1:0] a_4,
  input  logic [WIDTH-1:0] a_5,
  input  logic [WIDTH-1:0] a_6,
  input  logic [WIDTH-1:0] a_7,
  input  logic [WIDTH-1:0] a_8,
  input  sel_t             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
`ifdef MUX_8_1_PARITY_EN
  ,
  output logic             y_par
`endif
);

  // Handshake: in_valid qualifies a_*/sel on the rising edge it is sampled;
  // there is no ready, so every valid cycle is captured and out_valid pulses
  // exactly one cycle later for each capture.

  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;

  mux_8_1_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .a_1 (a_1),
    .a_2 (a_2),
    .a_3 (a_3),
    .a_4 (a_4),
    .a_5 (a_5),
    .a_6 (a_6),
    .a_7 (a_7),
    .a_8 (a_8),
    .sel (sel),
    .d   (w_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_y <= w_d;
      end
    end
  end

  assign y         = r_y;
  assign out_valid = r_valid;

`ifdef MUX_8_1_PARITY_EN
  logic r_par;

  // Parity tracks the captured word, so it only moves when y does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (in_valid) begin
      r_par <= ^w_d;
    end
  end

  assign y_par = r_par;
`endif

endmodule

// File: tb/tb_mux_8_1.sv
// Directed bench for mux_8_1: reset, select sweep, hold, random capture and optional parity.
module tb_mux_8_1;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_arr [8];
  logic [7:0] a_1, a_2, a_3, a_4, a_5, a_6, a_7, a_8;
  logic [2:0] sel;
  logic       in_valid;
  logic [7:0] y;
  logic       out_valid;
`ifdef MUX_8_1_PARITY_EN
  logic       y_par;
`endif

  int pass_cnt;
  int total_cnt;
  logic [7:0] exp_q[$];

  assign a_1 = a_arr[0];
  assign a_2 = a_arr[1];
  assign a_3 = a_arr[2];
  assign a_4 = a_arr[3];
  assign a_5 = a_arr[4];
  assign a_6 = a_arr[5];
  assign a_7 = a_arr[6];
  assign a_8 = a_arr[7];

  mux_8_1 #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_1       (a_1),
    .a_2       (a_2),
    .a_3       (a_3),
    .a_4       (a_4),
    .a_5       (a_5),
    .a_6       (a_6),
    .a_7       (a_7),
    .a_8       (a_8),
    .sel       (sel),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid)
`ifdef MUX_8_1_PARITY_EN
    ,
    .y_par     (y_par)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // advance past the next rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int i = 0; i < 8; i++) a_arr[i] = v;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sel       = 3'd0;
    set_all(8'h00);

    // reset state
    #12;
    check8("reset_y", y, 8'h00);
    check1("reset_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // asynchronous reset with prior y = A5
    a_arr[2] = 8'hA5;
    sel      = 3'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check8("pre_reset_y", y, 8'hA5);
    check1("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_reset_y", y, 8'h00);
    check1("async_reset_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // sweep: a_k = 10 + k
    for (int k = 0; k < 8; k++) a_arr[k] = 8'h11 + 8'(k);
    in_valid = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step();
      check8($sformatf("sweep_y_sel%0d", s), y, 8'h11 + 8'(s));
      check1($sformatf("sweep_valid_sel%0d", s), out_valid, 1'b1);
    end

    // top select code, via -1 truncated
    set_all(8'h00);
    a_arr[7] = 8'hFF;
    sel      = 3'(-1);
    step();
    check8("top_code_y", y, 8'hFF);

    // hold while inputs toggle
    set_all(8'h00);
    a_arr[4] = 8'h3C;
    sel      = 3'd4;
    step();
    check8("hold_capture_y", y, 8'h3C);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_all(8'(c * 37 + 5));
      sel = 3'(c + 1);
      step();
      check8($sformatf("hold_y_c%0d", c), y, 8'h3C);
      check1($sformatf("hold_valid_c%0d", c), out_valid, 1'b0);
    end

    // random captures against a scoreboard
    in_valid = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) a_arr[i] = 8'($urandom_range(0, 255));
      sel = 3'($urandom_range(0, 7));
      exp_q.push_back(a_arr[sel]);
      step();
      check8($sformatf("rand_y_%0d", r), y, exp_q.pop_front());
    end

    // reset mid-stream discards pending capture
    set_all(8'h5A);
    sel      = 3'd6;
    in_valid = 1'b1;
    @(negedge clk);
    rst_n    = 1'b0;
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check8("midstream_y", y, 8'h00);
    check1("midstream_valid", out_valid, 1'b0);

`ifdef MUX_8_1_PARITY_EN
    set_all(8'h00);
    a_arr[0] = 8'h07;
    sel      = 3'd0;
    in_valid = 1'b1;
    step();
    check8("par_y_07", y, 8'h07);
    check1("par_07", y_par, 1'b1);
    a_arr[0] = 8'h03;
    step();
    check1("par_03", y_par, 1'b0);
    in_valid = 1'b0;
    a_arr[0] = 8'h01;
    step();
    check1("par_hold", y_par, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
